// File: rtl/snoop_pkg.sv
// Shared MSI snoop bus encodings: op/kind codes, line states and bus field offsets.
// The cpu and bus_arbiter blocks import the same definitions.
package snoop_pkg;

  localparam logic [1:0] OP_DATA = 2'b00;
  localparam logic [1:0] OP_WB   = 2'b01;
  localparam logic [1:0] OP_REQ  = 2'b11;

  localparam logic [1:0] K_READ  = 2'b00;
  localparam logic [1:0] K_WRITE = 2'b01;
  localparam logic [1:0] K_INV   = 2'b10;
  localparam logic [1:0] K_NOP   = 2'b11;

  localparam logic [1:0] ST_I = 2'b00;
  localparam logic [1:0] ST_S = 2'b01;
  localparam logic [1:0] ST_M = 2'b10;

  // Field offsets of the default 10-bit bus {kind, op, tag, data}
  localparam int KIND_LSB = 8;
  localparam int OP_LSB   = 6;
  localparam int TAG_LSB  = 3;
  localparam int DATA_LSB = 0;

  typedef enum logic [1:0] {
    FSM_IDLE    = 2'b00,
    FSM_LOOKUP  = 2'b01,
    FSM_RESPOND = 2'b10,
    FSM_WB      = 2'b11
  } snoop_fsm_e;

  // The unused encoding 11 behaves exactly like Invalid.
  function automatic logic [1:0] msi_norm(input logic [1:0] s);
    return (s == 2'b11) ? ST_I : s;
  endfunction

endpackage

// File: rtl/snoop_line_array.sv
// Per-cache line store: NLINES x {state, tag, data} registers.
// One write port (local or snoop, muxed by the owner) and one combinational read port.
module snoop_line_array
  import snoop_pkg::*;
#(
  parameter int TAG_W  = 3,
  parameter int DATA_W = 3,
  parameter int IDX_W  = 1
) (
  input  logic              clock,
  input  logic              clear_n,
  input  logic              we,
  input  logic [IDX_W-1:0]  widx,
  input  logic [1:0]        wstate,
  input  logic [TAG_W-1:0]  wtag,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  ridx,
  output logic [1:0]        rstate,
  output logic [TAG_W-1:0]  rtag,
  output logic [DATA_W-1:0] rdata
);

  localparam int NLINES = 2 ** IDX_W;

  logic [1:0]        state_reg [NLINES];
  logic [TAG_W-1:0]  tag_reg   [NLINES];
  logic [DATA_W-1:0] data_reg  [NLINES];

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      for (int i = 0; i < NLINES; i++) begin
        state_reg[i] <= ST_I;
        tag_reg[i]   <= '0;
        data_reg[i]  <= '0;
      end
    end else if (we) begin
      state_reg[widx] <= wstate;
      tag_reg[widx]   <= wtag;
      data_reg[widx]  <= wdata;
    end
  end

  assign rstate = state_reg[ridx];
  assign rtag   = tag_reg[ridx];
  assign rdata  = data_reg[ridx];

endmodule

// File: rtl/snoop_responder.sv
// Snooping side of an MSI cache: samples bus requests, reports shared, and
// for a Modified hit issues a write-back before downgrading/invalidating the line.
module snoop_responder
  import snoop_pkg::*;
#(
  parameter int TAG_W  = 3,
  parameter int DATA_W = 3,
  parameter int IDX_W  = 1
) (
  input  logic                      clock,
  input  logic                      clear_n,
  input  logic                      hab,
  input  logic [TAG_W+DATA_W+3:0]   bus,
  input  logic                      loc_we,
  input  logic [TAG_W-1:0]          loc_tag,
  input  logic [DATA_W-1:0]         loc_data,
  input  logic [1:0]                loc_state,
  output logic                      shared,
  output logic [TAG_W+DATA_W+3:0]   bus_out,
  output logic                      wb_valid,
  output logic                      busy,
  output logic [1:0]                line_state
);

  snoop_fsm_e              fsm_reg;
  logic [1:0]              kind_reg;
  logic [TAG_W-1:0]        req_tag_reg;
  logic                    hit_reg;
  logic [1:0]              st_state_reg;
  logic [TAG_W-1:0]        st_tag_reg;
  logic [DATA_W-1:0]       st_data_reg;
  logic                    shared_reg;
  logic                    wb_valid_reg;
  logic [TAG_W+DATA_W+3:0] bus_out_reg;
  logic [1:0]              line_state_reg;

  logic [1:0]        bus_kind;
  logic [1:0]        bus_op;
  logic [TAG_W-1:0]  bus_tag;
  logic              unused_bus_data;
  logic              accept;
  logic              hit;
  logic [IDX_W-1:0]  req_idx;

  logic              arr_we;
  logic [IDX_W-1:0]  arr_widx;
  logic [1:0]        arr_wstate;
  logic [TAG_W-1:0]  arr_wtag;
  logic [DATA_W-1:0] arr_wdata;
  logic [1:0]        rd_state;
  logic [TAG_W-1:0]  rd_tag;
  logic [DATA_W-1:0] rd_data;

  assign bus_kind        = bus[TAG_W+DATA_W+3 -: 2];
  assign bus_op          = bus[TAG_W+DATA_W+1 -: 2];
  assign bus_tag         = bus[DATA_W +: TAG_W];
  assign unused_bus_data = ^bus[DATA_W-1:0];
  assign req_idx         = req_tag_reg[IDX_W-1:0];

  assign accept = (fsm_reg == FSM_IDLE) && hab && (bus_op == OP_REQ) && (bus_kind != K_NOP);
  assign hit    = (rd_tag == req_tag_reg) &&
                  ((msi_norm(rd_state) == ST_S) || (msi_norm(rd_state) == ST_M));

  // Snoop updates only touch the state field; tag/data are written back unchanged.
  always_comb begin
    arr_we     = 1'b0;
    arr_widx   = loc_tag[IDX_W-1:0];
    arr_wstate = loc_state;
    arr_wtag   = loc_tag;
    arr_wdata  = loc_data;
    if (fsm_reg == FSM_RESPOND && hit_reg && st_state_reg == ST_S && kind_reg != K_READ) begin
      arr_we     = 1'b1;
      arr_widx   = req_idx;
      arr_wstate = ST_I;
      arr_wtag   = st_tag_reg;
      arr_wdata  = st_data_reg;
    end else if (fsm_reg == FSM_WB) begin
      arr_we     = 1'b1;
      arr_widx   = req_idx;
      arr_wstate = (kind_reg == K_READ) ? ST_S : ST_I;
      arr_wtag   = st_tag_reg;
      arr_wdata  = st_data_reg;
    end else if (fsm_reg == FSM_IDLE && loc_we) begin
      arr_we = 1'b1;
    end
  end

  snoop_line_array #(
    .TAG_W  (TAG_W),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_array (
    .clock   (clock),
    .clear_n (clear_n),
    .we      (arr_we),
    .widx    (arr_widx),
    .wstate  (arr_wstate),
    .wtag    (arr_wtag),
    .wdata   (arr_wdata),
    .ridx    (req_idx),
    .rstate  (rd_state),
    .rtag    (rd_tag),
    .rdata   (rd_data)
  );

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      fsm_reg        <= FSM_IDLE;
      kind_reg       <= K_READ;
      req_tag_reg    <= '0;
      hit_reg        <= 1'b0;
      st_state_reg   <= ST_I;
      st_tag_reg     <= '0;
      st_data_reg    <= '0;
      shared_reg     <= 1'b0;
      wb_valid_reg   <= 1'b0;
      bus_out_reg    <= '0;
      line_state_reg <= ST_I;
    end else begin
      case (fsm_reg)
        FSM_IDLE: begin
          bus_out_reg  <= '0;
          wb_valid_reg <= 1'b0;
          if (accept) begin
            kind_reg    <= bus_kind;
            req_tag_reg <= bus_tag;
            shared_reg  <= 1'b0;
            fsm_reg     <= FSM_LOOKUP;
          end
        end
        FSM_LOOKUP: begin
          hit_reg      <= hit;
          st_state_reg <= msi_norm(rd_state);
          st_tag_reg   <= rd_tag;
          st_data_reg  <= rd_data;
          fsm_reg      <= FSM_RESPOND;
        end
        FSM_RESPOND: begin
          shared_reg     <= hit_reg;
          line_state_reg <= st_state_reg;
          fsm_reg        <= (hit_reg && st_state_reg == ST_M) ? FSM_WB : FSM_IDLE;
        end
        FSM_WB: begin
          bus_out_reg  <= {2'b00, OP_WB, st_tag_reg, st_data_reg};
          wb_valid_reg <= 1'b1;
          fsm_reg      <= FSM_IDLE;
        end
        default: fsm_reg <= FSM_IDLE;
      endcase
    end
  end

  assign shared     = shared_reg;
  assign bus_out    = bus_out_reg;
  assign wb_valid   = wb_valid_reg;
  assign busy       = (fsm_reg != FSM_IDLE);
  assign line_state = line_state_reg;

endmodule

// File: tb/tb_snoop_responder.sv
// Directed test of snoop_responder: hits/misses per MSI state, write-back timing,
// busy-time drops, local/snoop collision and asynchronous reset mid write-back.
module tb_snoop_responder;

  logic       clock;
  logic       clear_n;
  logic       hab;
  logic [9:0] bus;
  logic       loc_we;
  logic [2:0] loc_tag;
  logic [2:0] loc_data;
  logic [1:0] loc_state;
  logic       shared;
  logic [9:0] bus_out;
  logic       wb_valid;
  logic       busy;
  logic [1:0] line_state;

  int total = 0;
  int bad   = 0;

  snoop_responder dut (
    .clock      (clock),
    .clear_n    (clear_n),
    .hab        (hab),
    .bus        (bus),
    .loc_we     (loc_we),
    .loc_tag    (loc_tag),
    .loc_data   (loc_data),
    .loc_state  (loc_state),
    .shared     (shared),
    .bus_out    (bus_out),
    .wb_valid   (wb_valid),
    .busy       (busy),
    .line_state (line_state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic lw(input logic [1:0] st, input logic [2:0] tg, input logic [2:0] dt);
    @(negedge clock);
    loc_we = 1'b1; loc_state = st; loc_tag = tg; loc_data = dt;
    @(negedge clock);
    loc_we = 1'b0;
  endtask

  // Drives one request; returns at the falling edge right after the sampling edge.
  task automatic snoop(input logic [9:0] v);
    @(negedge clock);
    hab = 1'b1; bus = v;
    @(negedge clock);
    hab = 1'b0; bus = 10'b0;
  endtask

  // Read-miss to a non-matching tag: reports the indexed line state without changing it.
  task automatic probe(input string tag, input logic [2:0] t, input logic [1:0] exp_state);
    snoop({2'b00, 2'b11, t, 3'b000});
    step(2);
    chk({tag, "_shared"}, 10'(shared), 10'd0);
    chk({tag, "_state"}, 10'(line_state), 10'(exp_state));
    step(2);
  endtask

  initial begin
    clear_n = 1'b0; hab = 1'b0; bus = 10'b0;
    loc_we = 1'b0; loc_tag = 3'b0; loc_data = 3'b0; loc_state = 2'b0;
    step(2);
    clear_n = 1'b1;
    step(1);
    chk("rst_shared", 10'(shared), 10'd0);
    chk("rst_bus_out", bus_out, 10'd0);
    chk("rst_wb_valid", 10'(wb_valid), 10'd0);
    chk("rst_busy", 10'(busy), 10'd0);
    chk("rst_line_state", 10'(line_state), 10'd0);

    // Modified hit, read miss: write-back then downgrade to S
    lw(2'b10, 3'b000, 3'b110);
    snoop(10'b00_11_000_000);
    chk("rdM_busy", 10'(busy), 10'd1);
    step(1);
    chk("rdM_shared_early", 10'(shared), 10'd0);
    step(1);
    chk("rdM_shared", 10'(shared), 10'd1);
    chk("rdM_line_state", 10'(line_state), 10'b10);
    chk("rdM_wb_early", 10'(wb_valid), 10'd0);
    step(1);
    chk("rdM_bus_out", bus_out, 10'b00_01_000_110);
    chk("rdM_wb_valid", 10'(wb_valid), 10'd1);
    step(1);
    chk("rdM_wb_one_cycle", 10'(wb_valid), 10'd0);
    chk("rdM_bus_out_clr", bus_out, 10'd0);
    chk("rdM_busy_done", 10'(busy), 10'd0);
    probe("rdM_after", 3'b010, 2'b01);

    // Shared hit, write miss: no write-back, invalidate
    lw(2'b01, 3'b000, 3'b000);
    snoop(10'b01_11_000_000);
    step(2);
    chk("wrS_shared", 10'(shared), 10'd1);
    chk("wrS_line_state", 10'(line_state), 10'b01);
    step(1);
    chk("wrS_wb_valid", 10'(wb_valid), 10'd0);
    step(1);
    probe("wrS_after", 3'b010, 2'b00);

    // Same index, different tag: miss, line untouched
    lw(2'b10, 3'b010, 3'b101);
    snoop(10'b00_11_000_000);
    step(2);
    chk("miss_shared", 10'(shared), 10'd0);
    chk("miss_line_state", 10'(line_state), 10'b10);
    step(1);
    chk("miss_wb_valid", 10'(wb_valid), 10'd0);
    chk("miss_bus_out", bus_out, 10'd0);
    step(1);
    probe("miss_after", 3'b000, 2'b10);

    // Requests that must not start a transaction
    snoop(10'b11_11_010_000);
    chk("nop_busy", 10'(busy), 10'd0);
    snoop(10'b00_01_010_000);
    chk("wbop_busy", 10'(busy), 10'd0);

    // Second request and local write while busy are both dropped
    snoop(10'b00_11_010_000);
    hab = 1'b1; bus = 10'b10_11_010_000;
    loc_we = 1'b1; loc_state = 2'b00; loc_tag = 3'b100; loc_data = 3'b000;
    chk("busy_busy", 10'(busy), 10'd1);
    step(1);
    hab = 1'b0; bus = 10'b0; loc_we = 1'b0;
    step(1);
    chk("busy_shared", 10'(shared), 10'd1);
    step(1);
    chk("busy_bus_out", bus_out, 10'b00_01_010_101);
    chk("busy_wb_valid", 10'(wb_valid), 10'd1);
    step(1);
    chk("busy_idle", 10'(busy), 10'd0);
    probe("busy_after", 3'b000, 2'b01);

    // Local write and snoop in the same cycle: lookup sees the new line
    @(negedge clock);
    hab = 1'b1; bus = 10'b00_11_110_000;
    loc_we = 1'b1; loc_state = 2'b10; loc_tag = 3'b110; loc_data = 3'b011;
    @(negedge clock);
    hab = 1'b0; bus = 10'b0; loc_we = 1'b0;
    step(2);
    chk("coll_shared", 10'(shared), 10'd1);
    chk("coll_line_state", 10'(line_state), 10'b10);
    step(1);
    chk("coll_bus_out", bus_out, 10'b00_01_110_011);
    chk("coll_wb_valid", 10'(wb_valid), 10'd1);
    step(1);
    probe("coll_after", 3'b000, 2'b01);

    // Illegal state 11 on line 1 behaves as Invalid
    lw(2'b11, 3'b001, 3'b010);
    snoop(10'b10_11_001_000);
    step(2);
    chk("ill_shared", 10'(shared), 10'd0);
    chk("ill_line_state", 10'(line_state), 10'b00);
    step(1);
    chk("ill_wb_valid", 10'(wb_valid), 10'd0);
    step(1);

    // Asynchronous reset while in the write-back state
    lw(2'b10, 3'b000, 3'b110);
    snoop(10'b00_11_000_000);
    step(2);
    chk("rstwb_in_wb", 10'(busy), 10'd1);
    #1 clear_n = 1'b0;
    #1;
    chk("rstwb_bus_out", bus_out, 10'd0);
    chk("rstwb_wb_valid", 10'(wb_valid), 10'd0);
    chk("rstwb_busy", 10'(busy), 10'd0);
    chk("rstwb_shared", 10'(shared), 10'd0);
    step(1);
    chk("rstwb_held", 10'(wb_valid), 10'd0);
    clear_n = 1'b1;
    probe("rstwb_line0", 3'b010, 2'b00);
    probe("rstwb_line1", 3'b011, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
